// File: rtl/lvl_state_scanner.sv
// lvl_state_scanner
//
// Walks the level-state BRAM downward from a start level, looking for the
// first level whose has_bkt flag is 0. One read is issued per cycle and the
// BRAM read latency is a parameter. A lower scan bound is supported. Three
// modes are available: find-only, find+mark, and find+mark+clear. The block
// reports not-found and can be aborted mid-scan. While apply_find_o is high
// this block owns the level-state BRAM ports.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start_find            start request, sampled only in IDLE
//   abort_i               abandon the current scan
//   mode_i                0 find+mark, 1 find only, 2 find+mark+clear, 3 = 1
//   bkt_lvl_i             start level (scanned first)
//   lvl_floor_i           lowest level scanned
//   apply_find_o          BRAM mux ownership
//   done_find             one-cycle completion pulse
//   found_o               hit flag
//   bkt_lvl_o, bkt_bin_o  hit level and its bin id
//   scan_cnt_o            words examined, including the hit
//   ram_*_ls_*            level-state BRAM read/write ports, word = {bin_id, has_bkt}

module lvl_state_scanner #(
    parameter int WIDTH_LVL             = 16,
    parameter int WIDTH_BIN_ID          = 10,
    parameter int WIDTH_LVL_STATES      = 11,
    parameter int ADDR_WIDTH_LVL_STATES = 9,
    parameter int RD_LATENCY            = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_find,
    input  logic                             abort_i,
    input  logic [1:0]                       mode_i,
    input  logic [WIDTH_LVL-1:0]             bkt_lvl_i,
    input  logic [WIDTH_LVL-1:0]             lvl_floor_i,
    output logic                             apply_find_o,
    output logic                             done_find,
    output logic                             found_o,
    output logic [WIDTH_LVL-1:0]             bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]          bkt_bin_o,
    output logic [WIDTH_LVL-1:0]             scan_cnt_o,
    output logic [ADDR_WIDTH_LVL_STATES-1:0] ram_raddr_ls_o,
    input  logic [WIDTH_LVL_STATES-1:0]      ram_rdata_ls_i,
    output logic                             ram_we_ls_o,
    output logic [ADDR_WIDTH_LVL_STATES-1:0] ram_waddr_ls_o,
    output logic [WIDTH_LVL_STATES-1:0]      ram_wdata_ls_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, MARK, DONE} state_t;

    localparam int DRAIN_W = $clog2(2 * RD_LATENCY + 1);
    // After a hit, wait RD_LATENCY cycles. After the floor issue, first wait
    // for the floor word to return, then wait the same RD_LATENCY cycles a
    // hit on that word would need. This way both endings share one timing.
    localparam logic [DRAIN_W-1:0]   DRAIN_HIT   = DRAIN_W'(RD_LATENCY - 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_FLOOR = DRAIN_W'(2 * RD_LATENCY - 1);
    localparam logic [WIDTH_LVL-1:0] LVL_ONE     = {{(WIDTH_LVL-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [WIDTH_LVL-1:0]    floor_q;
    logic [WIDTH_LVL-1:0]    issue_lvl;
    logic                    issue_vld;
    logic                    mark_en;
    logic                    clr_en;
    logic [DRAIN_W-1:0]      drain_cnt;
    logic [RD_LATENCY-1:0]   pipe_vld;
    logic [WIDTH_LVL-1:0]    pipe_lvl [RD_LATENCY];

    logic                    start_ok;
    logic                    abort_ok;
    logic                    ret_vld;
    logic [WIDTH_LVL-1:0]    ret_lvl;
    logic [WIDTH_BIN_ID-1:0] ret_bin;
    logic                    hit;
    logic                    clr_hit;
    logic [WIDTH_LVL-1:0]    next_lvl;

    assign start_ok = (state == IDLE) && start_find;
    assign abort_ok = (state != IDLE) && abort_i;
    assign next_lvl = issue_lvl - LVL_ONE;

    // A returned word only counts while scanning and before the first hit.
    // Words that arrive after the hit are dropped here.
    assign ret_vld = pipe_vld[RD_LATENCY-1] && !found_o && ((state == ISSUE) || (state == DRAIN));
    assign ret_lvl = pipe_lvl[RD_LATENCY-1];
    assign ret_bin = ram_rdata_ls_i[WIDTH_LVL_STATES-1:1];
    assign hit     = ret_vld && !ram_rdata_ls_i[0];
    assign clr_hit = ret_vld && ram_rdata_ls_i[0] && clr_en;

    // The in-flight tracker follows each outstanding read so its level lines
    // up with the returning data. It is flushed on start and on abort, so
    // stale reads cannot leak into a new scan.
    always_ff @(posedge clk) begin
        if (rst || start_ok || abort_ok) begin
            pipe_vld <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            pipe_vld[0] <= issue_vld;
        end
        for (int i = RD_LATENCY - 1; i > 0; i--) begin
            pipe_lvl[i] <= pipe_lvl[i-1];
        end
        pipe_lvl[0] <= issue_lvl;
    end

    // Main control: state, read issue, result capture and all write traffic.
    // Write ports default to zero every cycle, so they are driven only in
    // the single cycle of a clear or mark write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            floor_q        <= '0;
            issue_lvl      <= '0;
            issue_vld      <= 1'b0;
            mark_en        <= 1'b0;
            clr_en         <= 1'b0;
            drain_cnt      <= '0;
            apply_find_o   <= 1'b0;
            done_find      <= 1'b0;
            found_o        <= 1'b0;
            bkt_lvl_o      <= '0;
            bkt_bin_o      <= '0;
            scan_cnt_o     <= '0;
            ram_raddr_ls_o <= '0;
            ram_we_ls_o    <= 1'b0;
            ram_waddr_ls_o <= '0;
            ram_wdata_ls_o <= '0;
        end else begin
            ram_we_ls_o    <= 1'b0;
            ram_waddr_ls_o <= '0;
            ram_wdata_ls_o <= '0;
            done_find      <= 1'b0;

            if (abort_ok) begin
                state          <= IDLE;
                issue_vld      <= 1'b0;
                ram_raddr_ls_o <= '0;
                apply_find_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        apply_find_o <= 1'b0;
                        if (start_find) begin
                            apply_find_o <= 1'b1;
                            floor_q      <= lvl_floor_i;
                            mark_en      <= (mode_i == 2'd0) || (mode_i == 2'd2);
                            clr_en       <= (mode_i == 2'd2);
                            scan_cnt_o   <= '0;
                            found_o      <= 1'b0;
                            bkt_lvl_o    <= '0;
                            bkt_bin_o    <= '0;
                            if (bkt_lvl_i < lvl_floor_i) begin
                                // Empty range. Spend one idle drain cycle
                                // with no reads, then report not-found.
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end else begin
                                state          <= ISSUE;
                                issue_vld      <= 1'b1;
                                issue_lvl      <= bkt_lvl_i;
                                ram_raddr_ls_o <= ADDR_WIDTH_LVL_STATES'(bkt_lvl_i);
                            end
                        end
                    end
                    ISSUE: begin
                        if (hit) begin
                            issue_vld      <= 1'b0;
                            ram_raddr_ls_o <= '0;
                            drain_cnt      <= DRAIN_HIT;
                            state          <= DRAIN;
                        end else if (issue_lvl == floor_q) begin
                            issue_vld      <= 1'b0;
                            ram_raddr_ls_o <= '0;
                            drain_cnt      <= DRAIN_FLOOR;
                            state          <= DRAIN;
                        end else begin
                            issue_lvl      <= next_lvl;
                            ram_raddr_ls_o <= ADDR_WIDTH_LVL_STATES'(next_lvl);
                        end
                    end
                    DRAIN: begin
                        if (hit) begin
                            drain_cnt <= DRAIN_HIT;
                        end else if (drain_cnt == '0) begin
                            if (found_o && mark_en) begin
                                state          <= MARK;
                                ram_we_ls_o    <= 1'b1;
                                ram_waddr_ls_o <= ADDR_WIDTH_LVL_STATES'(bkt_lvl_o);
                                ram_wdata_ls_o <= {bkt_bin_o, 1'b1};
                            end else begin
                                state     <= DONE;
                                done_find <= 1'b1;
                            end
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                    MARK: begin
                        state     <= DONE;
                        done_find <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase

                if (ret_vld) begin
                    scan_cnt_o <= scan_cnt_o + LVL_ONE;
                end
                if (hit) begin
                    found_o   <= 1'b1;
                    bkt_lvl_o <= ret_lvl;
                    bkt_bin_o <= ret_bin;
                end
                // Levels above the hit still carrying a bucket get their flag
                // cleared one cycle after the word returns. These writes
                // always finish before MARK, so they never collide with it.
                if (clr_hit) begin
                    ram_we_ls_o    <= 1'b1;
                    ram_waddr_ls_o <= ADDR_WIDTH_LVL_STATES'(ret_lvl);
                    ram_wdata_ls_o <= {ret_bin, 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_lvl_state_scanner.sv
// tb_lvl_state_scanner
//
// Drives two scanners from the same control inputs: one with read latency 1
// and one with read latency 3. Each has its own behavioural BRAM read
// pipeline over a shared memory image. Reads, writes, done pulses and
// ownership are logged with cycle numbers. Each scenario task then compares
// those logs and the result ports against hand-computed values.

module tb_lvl_state_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_find;
    logic        abort_i;
    logic [1:0]  mode_i;
    logic [15:0] bkt_lvl_i;
    logic [15:0] lvl_floor_i;

    logic        apply_l1, done_l1, found_l1, we_l1;
    logic [15:0] lvl_l1, cnt_l1;
    logic [9:0]  bin_l1;
    logic [8:0]  raddr_l1, waddr_l1;
    logic [10:0] rdata_l1, wdata_l1;

    logic        apply_l3, done_l3, found_l3, we_l3;
    logic [15:0] lvl_l3, cnt_l3;
    logic [9:0]  bin_l3;
    logic [8:0]  raddr_l3, waddr_l3;
    logic [10:0] rdata_l3, wdata_l3;

    logic [10:0] mem [512];
    logic [10:0] p3 [3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int rd_l1[$], rdc_l1[$], wa_l1[$], wd_l1[$], wc_l1[$], dn_l1[$], ap_l1[$];
    int rd_l3[$], rdc_l3[$], wa_l3[$], wd_l3[$], wc_l3[$], dn_l3[$], ap_l3[$];

    lvl_state_scanner #(.RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .start_find(start_find), .abort_i(abort_i), .mode_i(mode_i),
        .bkt_lvl_i(bkt_lvl_i), .lvl_floor_i(lvl_floor_i), .apply_find_o(apply_l1),
        .done_find(done_l1), .found_o(found_l1), .bkt_lvl_o(lvl_l1), .bkt_bin_o(bin_l1),
        .scan_cnt_o(cnt_l1), .ram_raddr_ls_o(raddr_l1), .ram_rdata_ls_i(rdata_l1),
        .ram_we_ls_o(we_l1), .ram_waddr_ls_o(waddr_l1), .ram_wdata_ls_o(wdata_l1)
    );

    lvl_state_scanner #(.RD_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .start_find(start_find), .abort_i(abort_i), .mode_i(mode_i),
        .bkt_lvl_i(bkt_lvl_i), .lvl_floor_i(lvl_floor_i), .apply_find_o(apply_l3),
        .done_find(done_l3), .found_o(found_l3), .bkt_lvl_o(lvl_l3), .bkt_bin_o(bin_l3),
        .scan_cnt_o(cnt_l3), .ram_raddr_ls_o(raddr_l3), .ram_rdata_ls_i(rdata_l3),
        .ram_we_ls_o(we_l3), .ram_waddr_ls_o(waddr_l3), .ram_wdata_ls_o(wdata_l3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM models: latency 1 is a single output register, latency 3 a
    // three-deep register chain.
    always @(posedge clk) begin
        rdata_l1 <= mem[raddr_l1];
        p3[0]    <= mem[raddr_l3];
        p3[1]    <= p3[0];
        p3[2]    <= p3[1];
    end
    assign rdata_l3 = p3[2];

    // Log BRAM traffic and handshakes away from the active edge. Level 0 is
    // never scanned in these scenarios, so a zero read address means idle.
    always @(negedge clk) begin
        if (raddr_l1 != 9'd0) begin rd_l1.push_back(int'(raddr_l1)); rdc_l1.push_back(cyc); end
        if (we_l1) begin wa_l1.push_back(int'(waddr_l1)); wd_l1.push_back(int'(wdata_l1)); wc_l1.push_back(cyc); end
        if (done_l1) dn_l1.push_back(cyc);
        if (apply_l1) ap_l1.push_back(cyc);
        if (raddr_l3 != 9'd0) begin rd_l3.push_back(int'(raddr_l3)); rdc_l3.push_back(cyc); end
        if (we_l3) begin wa_l3.push_back(int'(waddr_l3)); wd_l3.push_back(int'(wdata_l3)); wc_l3.push_back(cyc); end
        if (done_l3) dn_l3.push_back(cyc);
        if (apply_l3) ap_l3.push_back(cyc);
    end

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic clear_logs();
        rd_l1.delete(); rdc_l1.delete(); wa_l1.delete(); wd_l1.delete(); wc_l1.delete(); dn_l1.delete(); ap_l1.delete();
        rd_l3.delete(); rdc_l3.delete(); wa_l3.delete(); wd_l3.delete(); wc_l3.delete(); dn_l3.delete(); ap_l3.delete();
    endtask

    task automatic set_mem(input int a, input logic [9:0] bin, input logic bkt);
        mem[a] = {bin, bkt};
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = '0;
    endtask

    // Levels 5,4 hold a bucket; level 3 is {7,0}. Level 2 is also free, so
    // reading it after the hit must not change the result.
    task automatic load_basic_mem();
        clear_mem();
        set_mem(5, 10'd11, 1'b1);
        set_mem(4, 10'd12, 1'b1);
        set_mem(3, 10'd7,  1'b0);
        set_mem(2, 10'd5,  1'b0);
        set_mem(1, 10'd6,  1'b1);
    endtask

    // The start request is sampled at the end of cycle t.
    task automatic start_scan(input logic [15:0] s, input logic [15:0] f, input logic [1:0] m, output int t);
        @(negedge clk);
        t           = cyc;
        start_find  = 1'b1;
        bkt_lvl_i   = s;
        lvl_floor_i = f;
        mode_i      = m;
        @(negedge clk);
        start_find  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_find = 1'b0; abort_i = 1'b0; mode_i = 2'd0; bkt_lvl_i = '0; lvl_floor_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({apply_l1, done_l1, found_l1, lvl_l1, bin_l1, cnt_l1, raddr_l1, we_l1, waddr_l1, wdata_l1} !== '0) begin
            errors++; $display("[TB] FAIL reset_l1: outputs not all zero (found %0b cnt %0d raddr %0d)", found_l1, cnt_l1, raddr_l1);
        end
        checks++;
        if ({apply_l3, done_l3, found_l3, lvl_l3, bin_l3, cnt_l3, raddr_l3, we_l3, waddr_l3, wdata_l3} !== '0) begin
            errors++; $display("[TB] FAIL reset_l3: outputs not all zero (found %0b cnt %0d raddr %0d)", found_l3, cnt_l3, raddr_l3);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_find_mark();
        int t;
        int exp[$];
        load_basic_mem();
        clear_logs();
        start_scan(16'd5, 16'd1, 2'd0, t);
        repeat (16) @(negedge clk);
        exp = {5, 4, 3, 2};
        checks++;
        if (!same_q(rd_l1, exp) || first_of(rdc_l1) != t + 1) begin
            errors++; $display("[TB] FAIL mark_l1_reads: got %0d reads first at %0d, want 4 reads 5..2 first at %0d", rd_l1.size(), first_of(rdc_l1), t + 1);
        end
        exp = {t + 6};
        checks++;
        if (!same_q(wc_l1, exp) || first_of(wa_l1) != 3 || first_of(wd_l1) != 15) begin
            errors++; $display("[TB] FAIL mark_l1_write: got %0d writes first addr %0d data %0d, want 1 write addr 3 data 15 at %0d", wc_l1.size(), first_of(wa_l1), first_of(wd_l1), t + 6);
        end
        exp = {t + 7};
        checks++;
        if (!same_q(dn_l1, exp)) begin
            errors++; $display("[TB] FAIL mark_l1_done: got %0d pulses first at %0d, want one at %0d", dn_l1.size(), first_of(dn_l1), t + 7);
        end
        checks++;
        if ({found_l1, lvl_l1, bin_l1, cnt_l1} !== {1'b1, 16'd3, 10'd7, 16'd3}) begin
            errors++; $display("[TB] FAIL mark_l1_result: got found %0b lvl %0d bin %0d cnt %0d, want 1 3 7 3", found_l1, lvl_l1, bin_l1, cnt_l1);
        end
        checks++;
        if (ap_l1.size() != 8 || first_of(ap_l1) != t + 1) begin
            errors++; $display("[TB] FAIL mark_l1_apply: got %0d cycles first at %0d, want 8 from %0d", ap_l1.size(), first_of(ap_l1), t + 1);
        end
        exp = {5, 4, 3, 2, 1};
        checks++;
        if (!same_q(rd_l3, exp)) begin
            errors++; $display("[TB] FAIL mark_l3_reads: got %0d reads, want 5 reads 5..1", rd_l3.size());
        end
        exp = {t + 10};
        checks++;
        if (!same_q(wc_l3, exp) || first_of(wd_l3) != 15) begin
            errors++; $display("[TB] FAIL mark_l3_write: got %0d writes first at %0d data %0d, want data 15 at %0d", wc_l3.size(), first_of(wc_l3), first_of(wd_l3), t + 10);
        end
        exp = {t + 11};
        checks++;
        if (!same_q(dn_l3, exp) || cnt_l3 !== 16'd3 || lvl_l3 !== 16'd3) begin
            errors++; $display("[TB] FAIL mark_l3_done: got done at %0d cnt %0d lvl %0d, want done %0d cnt 3 lvl 3", first_of(dn_l3), cnt_l3, lvl_l3, t + 11);
        end
    endtask

    task automatic test_find_only();
        int t;
        int exp[$];
        load_basic_mem();
        clear_logs();
        start_scan(16'd5, 16'd1, 2'd1, t);
        repeat (16) @(negedge clk);
        exp = {t + 6};
        checks++;
        if (!same_q(dn_l1, exp) || wc_l1.size() != 0) begin
            errors++; $display("[TB] FAIL only_l1: got done at %0d with %0d writes, want done %0d and no writes", first_of(dn_l1), wc_l1.size(), t + 6);
        end
        exp = {t + 10};
        checks++;
        if (!same_q(dn_l3, exp) || wc_l3.size() != 0) begin
            errors++; $display("[TB] FAIL only_l3_timing: got done at %0d with %0d writes, want done %0d and no writes", first_of(dn_l3), wc_l3.size(), t + 10);
        end
        exp = {5, 4, 3, 2, 1};
        checks++;
        if (!same_q(rd_l3, exp)) begin
            errors++; $display("[TB] FAIL only_l3_reads: got %0d reads, want 5 reads stopping at the floor", rd_l3.size());
        end
        checks++;
        if ({found_l3, lvl_l3, bin_l3, cnt_l3} !== {1'b1, 16'd3, 10'd7, 16'd3}) begin
            errors++; $display("[TB] FAIL only_l3_result: got found %0b lvl %0d bin %0d cnt %0d, want 1 3 7 3", found_l3, lvl_l3, bin_l3, cnt_l3);
        end
    endtask

    task automatic test_find_clear();
        int t;
        int expc[$];
        int expa[$];
        int expd[$];
        clear_mem();
        set_mem(6, 10'd1, 1'b1);
        set_mem(5, 10'd2, 1'b1);
        set_mem(4, 10'd3, 1'b1);
        set_mem(3, 10'd9, 1'b0);
        set_mem(2, 10'd4, 1'b0);
        clear_logs();
        start_scan(16'd6, 16'd1, 2'd2, t);
        repeat (16) @(negedge clk);
        expa = {6, 5, 4, 3};
        expd = {2, 4, 6, 19};
        expc = {t + 3, t + 4, t + 5, t + 7};
        checks++;
        if (!same_q(wa_l1, expa) || !same_q(wd_l1, expd) || !same_q(wc_l1, expc)) begin
            errors++; $display("[TB] FAIL clear_l1_writes: got %0d writes first addr %0d data %0d at %0d, want clears 6,5,4 from %0d then mark 3", wc_l1.size(), first_of(wa_l1), first_of(wd_l1), first_of(wc_l1), t + 3);
        end
        checks++;
        if (first_of(dn_l1) != t + 8 || cnt_l1 !== 16'd4 || bin_l1 !== 10'd9) begin
            errors++; $display("[TB] FAIL clear_l1_result: got done %0d cnt %0d bin %0d, want done %0d cnt 4 bin 9", first_of(dn_l1), cnt_l1, bin_l1, t + 8);
        end
        expc = {t + 5, t + 6, t + 7, t + 11};
        checks++;
        if (!same_q(wa_l3, expa) || !same_q(wd_l3, expd) || !same_q(wc_l3, expc)) begin
            errors++; $display("[TB] FAIL clear_l3_writes: got %0d writes first at %0d, want clears from %0d and mark at %0d", wc_l3.size(), first_of(wc_l3), t + 5, t + 11);
        end
    endtask

    task automatic test_not_found();
        int t;
        int exp[$];
        clear_mem();
        set_mem(4, 10'd4, 1'b1);
        set_mem(3, 10'd3, 1'b1);
        set_mem(2, 10'd2, 1'b1);
        set_mem(1, 10'd1, 1'b0);
        clear_logs();
        start_scan(16'd4, 16'd2, 2'd0, t);
        repeat (16) @(negedge clk);
        exp = {4, 3, 2};
        checks++;
        if (!same_q(rd_l1, exp) || wc_l1.size() != 0) begin
            errors++; $display("[TB] FAIL nf_l1_traffic: got %0d reads %0d writes, want reads 4,3,2 and no writes", rd_l1.size(), wc_l1.size());
        end
        checks++;
        if ({found_l1, lvl_l1, bin_l1, cnt_l1} !== {1'b0, 16'd0, 10'd0, 16'd3}) begin
            errors++; $display("[TB] FAIL nf_l1_result: got found %0b lvl %0d bin %0d cnt %0d, want 0 0 0 3", found_l1, lvl_l1, bin_l1, cnt_l1);
        end
        checks++;
        if (first_of(dn_l1) != t + 6 || first_of(dn_l3) != t + 10) begin
            errors++; $display("[TB] FAIL nf_done: got l1 %0d l3 %0d, want l1 %0d l3 %0d", first_of(dn_l1), first_of(dn_l3), t + 6, t + 10);
        end
        checks++;
        if ({found_l3, cnt_l3} !== {1'b0, 16'd3} || wc_l3.size() != 0) begin
            errors++; $display("[TB] FAIL nf_l3_result: got found %0b cnt %0d writes %0d, want 0 3 0", found_l3, cnt_l3, wc_l3.size());
        end
    endtask

    task automatic test_immediate();
        int t;
        int exp[$];
        clear_logs();
        start_scan(16'd1, 16'd2, 2'd0, t);
        repeat (10) @(negedge clk);
        checks++;
        if (rd_l1.size() != 0 || rd_l3.size() != 0) begin
            errors++; $display("[TB] FAIL imm_reads: got l1 %0d l3 %0d reads, want none", rd_l1.size(), rd_l3.size());
        end
        exp = {t + 2};
        checks++;
        if (!same_q(dn_l1, exp) || !same_q(dn_l3, exp)) begin
            errors++; $display("[TB] FAIL imm_done: got l1 %0d l3 %0d, want %0d", first_of(dn_l1), first_of(dn_l3), t + 2);
        end
        checks++;
        if ({found_l1, cnt_l1, found_l3, cnt_l3} !== '0) begin
            errors++; $display("[TB] FAIL imm_result: got found %0b cnt %0d, want 0 0", found_l1, cnt_l1);
        end
    endtask

    task automatic test_busy_start();
        int t;
        int exp[$];
        load_basic_mem();
        clear_logs();
        start_scan(16'd5, 16'd1, 2'd1, t);
        @(negedge clk);
        start_find  = 1'b1;
        bkt_lvl_i   = 16'd9;
        lvl_floor_i = 16'd0;
        mode_i      = 2'd0;
        @(negedge clk);
        start_find  = 1'b0;
        repeat (14) @(negedge clk);
        exp = {5, 4, 3, 2};
        checks++;
        if (!same_q(rd_l1, exp) || wc_l1.size() != 0) begin
            errors++; $display("[TB] FAIL busy_l1_traffic: got %0d reads first %0d, %0d writes, want reads 5..2 and no writes", rd_l1.size(), first_of(rd_l1), wc_l1.size());
        end
        exp = {t + 6};
        checks++;
        if (!same_q(dn_l1, exp) || lvl_l1 !== 16'd3) begin
            errors++; $display("[TB] FAIL busy_l1_done: got done %0d lvl %0d, want done %0d lvl 3", first_of(dn_l1), lvl_l1, t + 6);
        end
        checks++;
        if (dn_l3.size() != 1 || wc_l3.size() != 0) begin
            errors++; $display("[TB] FAIL busy_l3: got %0d done pulses %0d writes, want 1 and 0", dn_l3.size(), wc_l3.size());
        end
    endtask

    task automatic test_abort();
        int t;
        int exp[$];
        load_basic_mem();
        clear_logs();
        start_scan(16'd5, 16'd1, 2'd0, t);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checks++;
        if ({apply_l1, apply_l3, raddr_l1, raddr_l3} !== '0) begin
            errors++; $display("[TB] FAIL abort_idle: got apply %0b/%0b raddr %0d/%0d, want all 0", apply_l1, apply_l3, raddr_l1, raddr_l3);
        end
        repeat (14) @(negedge clk);
        exp = {5, 4};
        checks++;
        if (!same_q(rd_l1, exp)) begin
            errors++; $display("[TB] FAIL abort_reads: got %0d reads, want 5,4 only", rd_l1.size());
        end
        checks++;
        if (dn_l1.size() + dn_l3.size() + wc_l1.size() + wc_l3.size() != 0) begin
            errors++; $display("[TB] FAIL abort_quiet: got done %0d/%0d writes %0d/%0d, want none", dn_l1.size(), dn_l3.size(), wc_l1.size(), wc_l3.size());
        end
    endtask

    task automatic test_reset_drain();
        int t;
        load_basic_mem();
        clear_logs();
        start_scan(16'd5, 16'd1, 2'd0, t);
        repeat (7) @(negedge clk);
        checks++;
        if ({found_l3, lvl_l3} !== {1'b1, 16'd3}) begin
            errors++; $display("[TB] FAIL rstd_pre: got found %0b lvl %0d before reset, want 1 3", found_l3, lvl_l3);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({apply_l3, done_l3, found_l3, lvl_l3, bin_l3, cnt_l3, we_l3} !== '0) begin
            errors++; $display("[TB] FAIL rstd_clear: got apply %0b found %0b lvl %0d cnt %0d, want all 0", apply_l3, found_l3, lvl_l3, cnt_l3);
        end
        clear_logs();
        repeat (12) @(negedge clk);
        checks++;
        if (dn_l3.size() + wc_l3.size() + ap_l3.size() != 0) begin
            errors++; $display("[TB] FAIL rstd_quiet: got done %0d writes %0d apply %0d, want none", dn_l3.size(), wc_l3.size(), ap_l3.size());
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_find_mark();
        test_find_only();
        test_find_clear();
        test_not_found();
        test_immediate();
        test_busy_start();
        test_abort();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lvl_state_scanner.md
# lvl_state_scanner

Parametrised successor to the global backtrack-level finder in the bin manager. It walks the level-state BRAM downward from a start level and finds the first level whose `has_bkt` flag is 0. The walk is pipelined: one read is issued per cycle, and the BRAM read latency is configurable. It supports a lower scan bound, a find-only mode, a find-and-mark mode and a find-mark-and-clear mode, reports not-found, and can be aborted mid-scan. It sits between the bin manager control FSM and the level-state BRAM, and owns the BRAM ports while `apply_find_o` is high.

## Interface
- `WIDTH_LVL`, 16, level number width.
- `WIDTH_BIN_ID`, 10, bin id width.
- `WIDTH_LVL_STATES`, 11, BRAM word width; always `WIDTH_BIN_ID+1`; word = `{bin_id, has_bkt}`.
- `ADDR_WIDTH_LVL_STATES`, 9, BRAM address width.
- `RD_LATENCY`, 1, BRAM read latency in cycles (legal 1..4).
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_find` in 1: start request; sampled only in IDLE.
- `abort_i` in 1: abandon the current scan.
- `mode_i` in 2: 0 = find+mark, 1 = find only, 2 = find+mark+clear, 3 = treated as 1; sampled with `start_find`.
- `bkt_lvl_i` in WIDTH_LVL: start level, scanned first.
- `lvl_floor_i` in WIDTH_LVL: lowest level scanned; sampled with `start_find`.
- `apply_find_o` out 1: BRAM mux ownership.
- `done_find` out 1: one-cycle completion pulse.
- `found_o` out 1: result valid-hit flag.
- `bkt_lvl_o` out WIDTH_LVL: hit level.
- `bkt_bin_o` out WIDTH_BIN_ID: `bin_id` at the hit level.
- `scan_cnt_o` out WIDTH_LVL: number of words examined, including the hit.
- `ram_raddr_ls_o` out ADDR_WIDTH_LVL_STATES: BRAM read address.
- `ram_rdata_ls_i` in WIDTH_LVL_STATES: BRAM read data.
- `ram_we_ls_o` out 1: BRAM write enable.
- `ram_waddr_ls_o` out ADDR_WIDTH_LVL_STATES: BRAM write address.
- `ram_wdata_ls_o` out WIDTH_LVL_STATES: BRAM write data.

## Operation
- **Addressing:** level L lives at address L, truncated to ADDR_WIDTH_LVL_STATES bits.
- **FSM states:** IDLE, ISSUE, DRAIN, MARK, DONE.
- **IDLE:**
  - `start_find` = 1 latches `bkt_lvl_i`, `lvl_floor_i` and `mode_i`, clears `scan_cnt_o`, and moves to ISSUE.
  - If `bkt_lvl_i < lvl_floor_i`, go directly to DONE with `found_o` = 0 and no reads.
- **ISSUE:**
  - One registered read per cycle; addresses run start, start-1, … down to the floor.
  - A shift register of depth RD_LATENCY tracks valid bit and level for every outstanding read.
  - Every returned valid word increments `scan_cnt_o`.
- **Hit:** a returned valid word with `has_bkt` = 0, and no earlier hit in this scan.
  - Latch `bkt_lvl_o` = its level and `bkt_bin_o` = its bin; set `found_o` = 1.
  - Stop issuing in the same cycle (the hit cycle H issues nothing).
  - Enter DRAIN. Words returning after the hit are discarded and not counted.
- **Floor reached without a hit:** after the floor address is issued, enter DRAIN. If the last returned word is not a hit, finish with `found_o` = 0, `bkt_lvl_o` = 0, `bkt_bin_o` = 0.
- **DRAIN:** lasts exactly RD_LATENCY cycles after the last issue or hit. Then:
  - hit and mode 0/2 → MARK;
  - otherwise → DONE.
- **MARK:** one write of `{bkt_bin_o, 1'b1}` to address `bkt_lvl_o`.
- **Mode 2 clear:**
  - Each returned word with `has_bkt` = 1 (necessarily above the hit) is written back as `{bin, 1'b0}` in the next cycle.
  - Clear writes never overlap MARK.
  - Not-found in mode 2 still clears every scanned level.
- **DONE:** `done_find` = 1 for one cycle, then IDLE. Results hold until the next accepted start.
- **`abort_i`:**
  - In any non-IDLE state → IDLE next cycle.
  - No MARK, no `done_find`. Clear writes already made are not undone. In-flight data is ignored.
  - Results registers are unchanged.
  - `abort_i` in IDLE has no effect.
- **Ownership:** `apply_find_o` = 1 from the cycle after start accepted until the cycle after DONE, inclusive.
- **Idle drive:** `ram_raddr_ls_o`, `ram_we_ls_o`, `ram_waddr_ls_o` and `ram_wdata_ls_o` are 0 whenever no access is being driven.
- **`start_find` while busy:** ignored.

## Timing
- **Reset:** all outputs 0 one cycle after `rst` = 1. Reset mid-scan behaves like an abort plus clearing of all results.
- **Read timing:** start accepted in cycle T; level `start-k` appears on `ram_raddr_ls_o` in cycle T+1+k; its data is valid at T+1+k+RD_LATENCY.
- **Hit in cycle H:**
  - mode 0/2: `ram_we_ls_o` = 1 at H+RD_LATENCY+1; `done_find` at H+RD_LATENCY+2;
  - mode 1: `done_find` at H+RD_LATENCY+1.
- **Not-found:** floor data returns in cycle F; `done_find` at F+RD_LATENCY+1.
- **Immediate not-found** (`bkt_lvl_i < lvl_floor_i`): `done_find` at T+2.
- **Clear write:** word returned in cycle X is written in cycle X+1.

## Test plan
- RD_LATENCY=1, mode 0, levels 5,4 `has_bkt`=1, level 3 = `{bin 7, 0}`, start 5, floor 1: reads 5,4,3,2 issued, read 2 discarded; write addr 3 data `{7,1}`; `found_o`=1, `bkt_lvl_o`=3, `bkt_bin_o`=7, `scan_cnt_o`=3.
- RD_LATENCY=3, same memory, mode 1: no write; `done_find` exactly at H+4; read addresses stop at 1 (floor).
- Mode 2, levels 6..4 = `{1,1}`,`{2,1}`,`{3,1}`, level 3 = `{9,0}`: clear writes `{1,0}`@6, `{2,0}`@5, `{3,0}`@4, then MARK `{9,1}`@3.
- All levels 4..2 `has_bkt`=1, start 4, floor 2, mode 0: `found_o`=0, `bkt_lvl_o`=0, no writes, `scan_cnt_o`=3.
- `bkt_lvl_i`=1, `lvl_floor_i`=2: no reads, `done_find` at T+2, `found_o`=0. `start_find` pulsed mid-scan is ignored.
- `abort_i` two cycles into a scan, and separately `rst` mid-DRAIN: IDLE next cycle, no `done_find`, no MARK write, `apply_find_o` low.
